// File: rtl/edge_evt_pkg.sv
// Shared constants, types and the round-robin pick helper for the edge event arbiter.
// Optional timestamping is enabled by defining EDGE_EVT_TS_EN.
package edge_evt_pkg;

  localparam int NUM_CH_DEF = 4;
  localparam int TS_W_DEF   = 16;
  localparam int MAX_CH     = 32;

  typedef logic [TS_W_DEF-1:0] ts_t;

  typedef struct packed {
    logic       found;
    logic [4:0] id;
  } rr_pick_t;

  // First set bit of pending at or above rr_ptr, wrapping modulo num_ch.
  function automatic rr_pick_t rr_pick(input logic [MAX_CH-1:0] pending,
                                       input logic [4:0]        rr_ptr,
                                       input int                num_ch);
    rr_pick_t res;
    int       idx;
    res.found = 1'b0;
    res.id    = 5'd0;
    for (int off = 0; off < MAX_CH; off++) begin
      idx = int'(rr_ptr) + off;
      if (idx >= num_ch) begin
        idx = idx - num_ch;
      end else begin
        idx = idx;
      end
      if ((off < num_ch) && !res.found && pending[idx[4:0]]) begin
        res.found = 1'b1;
        res.id    = idx[4:0];
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/edge_pend_ch.sv
// One channel: rising-edge detect, pending latch, sticky overflow and optional
// timestamp capture (EDGE_EVT_TS_EN).
module edge_pend_ch
  import edge_evt_pkg::*;
`ifdef EDGE_EVT_TS_EN
#(
  parameter int TS_W = TS_W_DEF
)
`endif
(
  input  logic clk,
  input  logic reset_n,
  input  logic data_i,
  input  logic load_i,
  input  logic ovf_clr_i,
  output logic pending_o,
  output logic ovf_o
`ifdef EDGE_EVT_TS_EN
  ,
  input  logic [TS_W-1:0] ts_now_i,
  output logic [TS_W-1:0] ts_o
`endif
);

  logic data_q, data_d;
  logic pending_q, pending_d;
  logic ovf_q, ovf_d;
  logic edge_s;
  logic keep_s;

  // Edge detect and pending/overflow next state; a fresh edge survives a same-cycle load.
  always_comb begin
    edge_s    = data_i & ~data_q;
    keep_s    = pending_q & ~load_i;
    data_d    = data_i;
    pending_d = edge_s | keep_s;
    ovf_d     = (edge_s & keep_s) | (ovf_q & ~ovf_clr_i);
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q    <= 1'b0;
      pending_q <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      data_q    <= data_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
    end
  end

  assign pending_o = pending_q;
  assign ovf_o     = ovf_q;

`ifdef EDGE_EVT_TS_EN
  logic [TS_W-1:0] ts_q, ts_d;

  // Capture only when a new event is queued, never on a merged edge.
  always_comb begin
    if (edge_s && !keep_s) begin
      ts_d = ts_now_i;
    end else begin
      ts_d = ts_q;
    end
  end

  // Timestamp register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_q <= '0;
    end else begin
      ts_q <= ts_d;
    end
  end

  assign ts_o = ts_q;
`endif

endmodule

// File: rtl/edge_event_arbiter.sv
// Multi-channel rising-edge event scheduler with round-robin drain onto one valid/ready port.
// Define EDGE_EVT_TS_EN to add a free-running timestamp and the evt_ts_o port.
module edge_event_arbiter
  import edge_evt_pkg::*;
#(
  parameter int NUM_CH = NUM_CH_DEF
`ifdef EDGE_EVT_TS_EN
  ,
  parameter int TS_W = TS_W_DEF
`endif
)(
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_CH-1:0]         data_i,
  output logic                      evt_valid_o,
  output logic [$clog2(NUM_CH)-1:0] evt_id_o,
  input  logic                      evt_ready_i,
  output logic [NUM_CH-1:0]         ovf_o,
  input  logic                      ovf_clr_i
`ifdef EDGE_EVT_TS_EN
  ,
  output logic [TS_W-1:0]           evt_ts_o
`endif
);

  localparam int ID_W = $clog2(NUM_CH);

  logic [NUM_CH-1:0] pending_s;
  logic [NUM_CH-1:0] load_vec_s;
  logic [NUM_CH-1:0] ovf_s;
  rr_pick_t          pick_s;
  logic              load_s;
  logic [ID_W-1:0]   win_id_s;

  logic              evt_valid_q, evt_valid_d;
  logic [ID_W-1:0]   evt_id_q, evt_id_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;

`ifdef EDGE_EVT_TS_EN
  logic [TS_W-1:0]   ts_cnt_q, ts_cnt_d;
  logic [TS_W-1:0]   evt_ts_q, evt_ts_d;
  logic [TS_W-1:0]   chan_ts_s [NUM_CH];
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    edge_pend_ch
`ifdef EDGE_EVT_TS_EN
      #(.TS_W(TS_W))
`endif
    u_ch (
      .clk       (clk),
      .reset_n   (reset_n),
      .data_i    (data_i[g]),
      .load_i    (load_vec_s[g]),
      .ovf_clr_i (ovf_clr_i),
      .pending_o (pending_s[g]),
      .ovf_o     (ovf_s[g])
`ifdef EDGE_EVT_TS_EN
      ,
      .ts_now_i  (ts_cnt_q),
      .ts_o      (chan_ts_s[g])
`endif
    );
  end

  // Arbitration: the output register takes a winner whenever it is empty or being accepted.
  always_comb begin
    pick_s   = rr_pick(MAX_CH'(pending_s), 5'(rr_ptr_q), NUM_CH);
    win_id_s = ID_W'(pick_s.id);
    load_s   = (~evt_valid_q | evt_ready_i) & pick_s.found;
    for (int i = 0; i < NUM_CH; i++) begin
      load_vec_s[i] = load_s && (win_id_s == ID_W'(i));
    end
  end

  // Output register and pointer next state.
  always_comb begin
    if (load_s) begin
      evt_valid_d = 1'b1;
      evt_id_d    = win_id_s;
      if (win_id_s == ID_W'(NUM_CH - 1)) begin
        rr_ptr_d = '0;
      end else begin
        rr_ptr_d = win_id_s + ID_W'(1);
      end
    end else begin
      evt_id_d = evt_id_q;
      rr_ptr_d = rr_ptr_q;
      if (evt_ready_i) begin
        evt_valid_d = 1'b0;
      end else begin
        evt_valid_d = evt_valid_q;
      end
    end
  end

  // Arbiter state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      rr_ptr_q    <= '0;
    end else begin
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  assign evt_valid_o = evt_valid_q;
  assign evt_id_o    = evt_id_q;
  assign ovf_o       = ovf_s;

`ifdef EDGE_EVT_TS_EN
  // Free-running counter and timestamp travelling with the presented id.
  always_comb begin
    ts_cnt_d = ts_cnt_q + TS_W'(1);
    if (load_s) begin
      evt_ts_d = chan_ts_s[win_id_s];
    end else begin
      evt_ts_d = evt_ts_q;
    end
  end

  // Timestamp registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_cnt_q <= '0;
      evt_ts_q <= '0;
    end else begin
      ts_cnt_q <= ts_cnt_d;
      evt_ts_q <= evt_ts_d;
    end
  end

  assign evt_ts_o = evt_ts_q;
`endif

endmodule

// File: tb/tb_edge_event_arbiter.sv
// Directed self-checking bench for edge_event_arbiter (NUM_CH=4).
module tb_edge_event_arbiter;

  logic       clk;
  logic       reset_n;
  logic [3:0] data_i;
  logic       evt_valid_o;
  logic [1:0] evt_id_o;
  logic       evt_ready_i;
  logic [3:0] ovf_o;
  logic       ovf_clr_i;
`ifdef EDGE_EVT_TS_EN
  logic [15:0] evt_ts_o;
`endif

  int n_chk;
  int n_fail;

  edge_event_arbiter #(.NUM_CH(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .data_i      (data_i),
    .evt_valid_o (evt_valid_o),
    .evt_id_o    (evt_id_o),
    .evt_ready_i (evt_ready_i),
    .ovf_o       (ovf_o),
    .ovf_clr_i   (ovf_clr_i)
`ifdef EDGE_EVT_TS_EN
    ,
    .evt_ts_o    (evt_ts_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_evt(input string tag, input logic v, input logic [1:0] id);
    chk({tag, ".valid"}, 32'(evt_valid_o), 32'(v));
    if (v) chk({tag, ".id"}, 32'(evt_id_o), 32'(id));
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    reset_n = 1'b0; data_i = 4'b0000; evt_ready_i = 1'b0; ovf_clr_i = 1'b0;
    #12;
    chk("rst.valid", 32'(evt_valid_o), 32'd0);
    chk("rst.id",    32'(evt_id_o),    32'd0);
    chk("rst.ovf",   32'(ovf_o),       32'd0);
    tick(); reset_n = 1'b1;
    tick(); tick();

    // single edge on ch2, two-clock latency
    data_i = 4'b0100;
    tick(); chk_evt("t1.lat1", 1'b0, 2'd0);
    tick(); chk_evt("t1.lat2", 1'b1, 2'd2);
    evt_ready_i = 1'b1;
    tick(); chk_evt("t1.drop", 1'b0, 2'd0);

    // ch3 alone, pointer wraps to 0
    data_i = 4'b1000;
    tick(); tick(); chk_evt("t1b.id3", 1'b1, 2'd3);
    tick(); chk_evt("t1b.drop", 1'b0, 2'd0);

    // fairness from rr_ptr=0
    data_i = 4'b0000; tick();
    data_i = 4'b1111; tick(); chk_evt("t2.lat", 1'b0, 2'd0);
    tick(); chk_evt("t2.a0", 1'b1, 2'd0);
    tick(); chk_evt("t2.a1", 1'b1, 2'd1);
    tick(); chk_evt("t2.a2", 1'b1, 2'd2);
    tick(); chk_evt("t2.a3", 1'b1, 2'd3);
    tick(); chk_evt("t2.aend", 1'b0, 2'd0);

    // fairness from rr_ptr=2 (set by a lone ch1 event)
    data_i = 4'b0000; tick();
    data_i = 4'b0010; tick();
    data_i = 4'b0000; tick(); chk_evt("t2.c1", 1'b1, 2'd1);
    data_i = 4'b1111; tick(); chk_evt("t2.gap", 1'b0, 2'd0);
    tick(); chk_evt("t2.b2", 1'b1, 2'd2);
    tick(); chk_evt("t2.b3", 1'b1, 2'd3);
    tick(); chk_evt("t2.b0", 1'b1, 2'd0);
    tick(); chk_evt("t2.b1", 1'b1, 2'd1);
    tick(); chk_evt("t2.bend", 1'b0, 2'd0);

    // backpressure: ch1 then ch3 while ready low
    evt_ready_i = 1'b0;
    data_i = 4'b0000; tick();
    data_i = 4'b0010; tick();
    data_i = 4'b1010; tick(); chk_evt("t3.h0", 1'b1, 2'd1);
    tick(); chk_evt("t3.h1", 1'b1, 2'd1);
    tick(); chk_evt("t3.h2", 1'b1, 2'd1);
    chk("t3.ovf0", 32'(ovf_o), 32'd0);
    evt_ready_i = 1'b1;
    tick(); chk_evt("t3.id3", 1'b1, 2'd3);
    tick(); chk_evt("t3.end", 1'b0, 2'd0);
    chk("t3.ovf1", 32'(ovf_o), 32'd0);

    // overflow on ch0 while port held by ch1
    evt_ready_i = 1'b0;
    data_i = 4'b0000; tick();
    data_i = 4'b0010; tick();
    data_i = 4'b0000; tick();
    data_i = 4'b0001; tick();
    data_i = 4'b0000; tick();
    data_i = 4'b0001; tick();
    chk("t4.ovf", 32'(ovf_o), 32'd1);
    chk_evt("t4.hold", 1'b1, 2'd1);
    evt_ready_i = 1'b1;
    tick(); chk_evt("t4.id0", 1'b1, 2'd0);
    tick(); chk_evt("t4.once", 1'b0, 2'd0);
    evt_ready_i = 1'b0;
    ovf_clr_i = 1'b1; tick(); ovf_clr_i = 1'b0;
    chk("t4.clr", 32'(ovf_o), 32'd0);

    // overflow set and clear in the same cycle: set wins
    data_i = 4'b0000; tick();
    data_i = 4'b0010; tick();
    data_i = 4'b0000; tick();
    data_i = 4'b0001; tick();
    data_i = 4'b0000; tick();
    data_i = 4'b0001; ovf_clr_i = 1'b1; tick(); ovf_clr_i = 1'b0;
    chk("t4.setwins", 32'(ovf_o), 32'd1);
    evt_ready_i = 1'b1;
    tick(); chk_evt("t4.id0b", 1'b1, 2'd0);
    tick(); chk_evt("t4.endb", 1'b0, 2'd0);
    ovf_clr_i = 1'b1; tick(); ovf_clr_i = 1'b0;
    chk("t4.clr2", 32'(ovf_o), 32'd0);

    // re-pend of ch1 in the cycle it is loaded
    evt_ready_i = 1'b0;
    data_i = 4'b0000; tick();
    data_i = 4'b1000; tick();
    data_i = 4'b0010; tick(); chk_evt("t5.id3", 1'b1, 2'd3);
    data_i = 4'b0000; tick();
    data_i = 4'b0010; evt_ready_i = 1'b1; tick(); chk_evt("t5.first", 1'b1, 2'd1);
    chk("t5.ovf", 32'(ovf_o), 32'd0);
    data_i = 4'b0000; tick(); chk_evt("t5.second", 1'b1, 2'd1);
    tick(); chk_evt("t5.end", 1'b0, 2'd0);

    // reset mid-stream with id0 presented and 1010 pending
    evt_ready_i = 1'b0;
    data_i = 4'b0000; tick();
    data_i = 4'b0001; tick();
    data_i = 4'b1011; tick(); chk_evt("t6.pre", 1'b1, 2'd0);
    reset_n = 1'b0; #1;
    chk("t6.valid", 32'(evt_valid_o), 32'd0);
    chk("t6.id",    32'(evt_id_o),    32'd0);
    chk("t6.ovf",   32'(ovf_o),       32'd0);
    #2; reset_n = 1'b1; evt_ready_i = 1'b1;
    tick(); chk_evt("t6.lat", 1'b0, 2'd0);
    tick(); chk_evt("t6.r0", 1'b1, 2'd0);
`ifdef EDGE_EVT_TS_EN
    chk("t6.ts0", 32'(evt_ts_o), 32'd0);
`endif
    tick(); chk_evt("t6.r1", 1'b1, 2'd1);
    tick(); chk_evt("t6.r3", 1'b1, 2'd3);
    tick(); chk_evt("t6.end", 1'b0, 2'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
